// File: rtl/alu_op_sequencer.sv
// Multi-cycle ALU op sequencer: single-cycle add/sub/and/or/shl, iterative shift-add mul.
// Optional macro ALU_SEQ_MUL_EARLY_EXIT_EN ends mul once the remaining multiplier bits are zero.
module alu_op_sequencer #(
  parameter int DATA_WIDTH = 16,
  parameter int CNT_WIDTH  = 5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [2:0]            alu_ctrl,
  input  logic [DATA_WIDTH-1:0] op_a,
  input  logic [DATA_WIDTH-1:0] op_b,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] result,
  output logic                  zero,
  output logic                  illegal,
  output logic                  busy
);

  typedef enum logic [1:0] {IDLE, MUL, DONE} state_t;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_SHL = 3'b100;
  localparam logic [2:0] OP_MUL = 3'b101;

  state_t                  state;
  logic [DATA_WIDTH-1:0]   mcand;
  logic [DATA_WIDTH-1:0]   mplier;
  logic [DATA_WIDTH-1:0]   acc;
  logic [CNT_WIDTH-1:0]    cnt;

  logic [DATA_WIDTH-1:0]   acc_step;
  logic [DATA_WIDTH-1:0]   mplier_shr;
  logic                    mul_last;
  logic [DATA_WIDTH:0]     single_res;

  // Single-cycle ops; MSB of the return value flags an illegal code (result forced to 0).
  function automatic logic [DATA_WIDTH:0] alu_eval(
    input logic [2:0]            ctrl,
    input logic [DATA_WIDTH-1:0] a,
    input logic [DATA_WIDTH-1:0] b
  );
    logic [DATA_WIDTH:0] r;
    r = '0;
    case (ctrl)
      OP_ADD:  r[DATA_WIDTH-1:0] = a + b;
      OP_SUB:  r[DATA_WIDTH-1:0] = a - b;
      OP_AND:  r[DATA_WIDTH-1:0] = a & b;
      OP_OR:   r[DATA_WIDTH-1:0] = a | b;
      OP_SHL:  r[DATA_WIDTH-1:0] = a << b[3:0];
      default: r[DATA_WIDTH]     = 1'b1;
    endcase
    return r;
  endfunction

  assign single_res = alu_eval(alu_ctrl, op_a, op_b);
  assign acc_step   = mplier[0] ? (acc + mcand) : acc;
  assign mplier_shr = mplier >> 1;

`ifdef ALU_SEQ_MUL_EARLY_EXIT_EN
  assign mul_last = (cnt == CNT_WIDTH'(DATA_WIDTH - 1)) || (mplier_shr == '0);
`else
  assign mul_last = (cnt == CNT_WIDTH'(DATA_WIDTH - 1));
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      result    <= '0;
      zero      <= 1'b0;
      illegal   <= 1'b0;
      mcand     <= '0;
      mplier    <= '0;
      acc       <= '0;
      cnt       <= '0;
    end else if (flush) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid && in_ready) begin
            in_ready <= 1'b0;
            busy     <= 1'b1;
            if (alu_ctrl == OP_MUL) begin
              state  <= MUL;
              mcand  <= op_a;
              mplier <= op_b;
              acc    <= '0;
              cnt    <= '0;
            end else begin
              state     <= DONE;
              out_valid <= 1'b1;
              result    <= single_res[DATA_WIDTH-1:0];
              illegal   <= single_res[DATA_WIDTH];
              zero      <= (single_res[DATA_WIDTH-1:0] == '0);
            end
          end
        end
        MUL: begin
          acc    <= acc_step;
          mcand  <= mcand << 1;
          mplier <= mplier_shr;
          cnt    <= cnt + 1'b1;
          if (mul_last) begin
            state     <= DONE;
            out_valid <= 1'b1;
            result    <= acc_step;
            illegal   <= 1'b0;
            zero      <= (acc_step == '0);
          end
        end
        DONE: begin
          // Result stays put until the consumer takes it; in_ready returns a cycle later.
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            busy      <= 1'b0;
          end
        end
        default: begin
          state     <= IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed self-checking bench for alu_op_sequencer (handles either mul early-exit build).
module tb_alu_op_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  alu_ctrl;
  logic [15:0] op_a;
  logic [15:0] op_b;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] result;
  logic        zero;
  logic        illegal;
  logic        busy;

  int errors = 0;
  int checks = 0;
  int lat;
  bit seen;

`ifdef ALU_SEQ_MUL_EARLY_EXIT_EN
  localparam int LAT_MUL_3X5   = 4;
  localparam int LAT_MUL_100   = 10;
  localparam int LAT_MUL_BZERO = 2;
  localparam int LAT_MUL_7X9   = 5;
`else
  localparam int LAT_MUL_3X5   = 17;
  localparam int LAT_MUL_100   = 17;
  localparam int LAT_MUL_BZERO = 17;
  localparam int LAT_MUL_7X9   = 17;
`endif

  always #5 clk = ~clk;

  alu_op_sequencer #(.DATA_WIDTH(16), .CNT_WIDTH(5)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .alu_ctrl(alu_ctrl),
    .op_a(op_a), .op_b(op_b),
    .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .zero(zero), .illegal(illegal), .busy(busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Present one op, take the accept edge, then count edges until out_valid (bounded).
  task automatic issue(input logic [2:0] ctrl, input logic [15:0] a, input logic [15:0] b);
    @(negedge clk);
    alu_ctrl = ctrl; op_a = a; op_b = b; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    op_a = 16'hDEAD; op_b = 16'hBEEF; alu_ctrl = 3'b000;
    lat = 1;
    while (!out_valid && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic consume();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("consume_out_valid", 32'(out_valid), 32'd0);
    chk("consume_in_ready", 32'(in_ready), 32'd1);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_in_ready"}, 32'(in_ready), 32'd1);
    chk({tag, "_out_valid"}, 32'(out_valid), 32'd0);
    chk({tag, "_result"}, 32'(result), 32'd0);
    chk({tag, "_zero"}, 32'(zero), 32'd0);
    chk({tag, "_illegal"}, 32'(illegal), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
  endtask

  initial begin
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    alu_ctrl = 3'b000; op_a = '0; op_b = '0;
    repeat (2) @(posedge clk);
    #1;
    chk_reset_outputs("reset");
    @(negedge clk); rst_n = 1'b1;

    // 1: add wraps into the sign bit
    issue(3'b000, 16'h7FFF, 16'h0001);
    chk("add_lat", 32'(lat), 32'd1);
    chk("add_result", 32'(result), 32'h8000);
    chk("add_zero", 32'(zero), 32'd0);
    chk("add_busy", 32'(busy), 32'd1);
    consume();

    // 2: sub to zero, then back-pressure with a competing op on the inputs
    issue(3'b001, 16'h1234, 16'h1234);
    chk("sub_lat", 32'(lat), 32'd1);
    chk("sub_result", 32'(result), 32'h0000);
    chk("sub_zero", 32'(zero), 32'd1);
    alu_ctrl = 3'b000; op_a = 16'h0005; op_b = 16'h0006; in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("hold_out_valid", 32'(out_valid), 32'd1);
      chk("hold_result", 32'(result), 32'h0000);
      chk("hold_in_ready", 32'(in_ready), 32'd0);
    end
    in_valid = 1'b0;
    consume();
    @(posedge clk); #1;
    chk("no_stray_accept", 32'(out_valid), 32'd0);

    // sub wrap, and, or
    issue(3'b001, 16'h0000, 16'h0001);
    chk("subwrap_result", 32'(result), 32'hFFFF);
    chk("subwrap_zero", 32'(zero), 32'd0);
    consume();
    issue(3'b010, 16'hF0F0, 16'h0FF0);
    chk("and_result", 32'(result), 32'h00F0);
    consume();
    issue(3'b011, 16'hF000, 16'h000F);
    chk("or_result", 32'(result), 32'hF00F);
    consume();

    // 3: mul latency and busy across the whole op
    @(negedge clk);
    alu_ctrl = 3'b101; op_a = 16'h0003; op_b = 16'h0005; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; op_a = 16'hFFFF; op_b = 16'hFFFF;
    chk("mul_busy_early", 32'(busy), 32'd1);
    chk("mul_in_ready_early", 32'(in_ready), 32'd0);
    lat = 1;
    while (!out_valid && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("mul3x5_lat", 32'(lat), 32'(LAT_MUL_3X5));
    chk("mul3x5_result", 32'(result), 32'h000F);
    chk("mul3x5_zero", 32'(zero), 32'd0);
    @(posedge clk); #1;
    chk("mul_busy_done", 32'(busy), 32'd1);
    consume();
    chk("mul_busy_after", 32'(busy), 32'd0);

    // 4: truncated mul, multiplier zero, shl uses low 4 bits only
    issue(3'b101, 16'h0100, 16'h0100);
    chk("mul100_lat", 32'(lat), 32'(LAT_MUL_100));
    chk("mul100_result", 32'(result), 32'h0000);
    chk("mul100_zero", 32'(zero), 32'd1);
    consume();
    issue(3'b101, 16'h1234, 16'h0000);
    chk("mulb0_lat", 32'(lat), 32'(LAT_MUL_BZERO));
    chk("mulb0_result", 32'(result), 32'h0000);
    consume();
    issue(3'b100, 16'h0001, 16'h0013);
    chk("shl_lat", 32'(lat), 32'd1);
    chk("shl_result", 32'(result), 32'h0008);
    consume();

    // 5: illegal code
    issue(3'b110, 16'h1111, 16'h2222);
    chk("ill_lat", 32'(lat), 32'd1);
    chk("ill_flag", 32'(illegal), 32'd1);
    chk("ill_result", 32'(result), 32'h0000);
    chk("ill_zero", 32'(zero), 32'd1);
    consume();
    issue(3'b111, 16'h0001, 16'h0001);
    chk("ill7_flag", 32'(illegal), 32'd1);
    consume();
    issue(3'b000, 16'h0001, 16'h0002);
    chk("ill_clear_flag", 32'(illegal), 32'd0);
    chk("ill_clear_result", 32'(result), 32'h0003);
    consume();

    // flush during MUL cycle 4
    @(negedge clk);
    alu_ctrl = 3'b101; op_a = 16'hFFFF; op_b = 16'hFFFF; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("preflush_busy", 32'(busy), 32'd1);
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    chk("flush_in_ready", 32'(in_ready), 32'd1);
    chk("flush_busy", 32'(busy), 32'd0);
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (out_valid) seen = 1'b1;
      @(posedge clk); #1;
    end
    chk("flush_no_out_valid", 32'(seen), 32'd0);

    // flush and in_valid together in IDLE: op dropped
    @(negedge clk);
    alu_ctrl = 3'b000; op_a = 16'h0001; op_b = 16'h0001; in_valid = 1'b1; flush = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; flush = 1'b0;
    chk("flushacc_in_ready", 32'(in_ready), 32'd1);
    chk("flushacc_busy", 32'(busy), 32'd0);
    @(posedge clk); #1;
    chk("flushacc_out_valid", 32'(out_valid), 32'd0);

    // 6: async reset in MUL cycle 8
    @(negedge clk);
    alu_ctrl = 3'b101; op_a = 16'h00FF; op_b = 16'hFFFF; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (7) @(posedge clk);
    #2;
    chk("premrst_busy", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    chk_reset_outputs("midreset");
    @(negedge clk); rst_n = 1'b1;
    issue(3'b101, 16'h0007, 16'h0009);
    chk("mul7x9_lat", 32'(lat), 32'(LAT_MUL_7X9));
    chk("mul7x9_result", 32'(result), 32'd63);
    consume();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
